// File: rtl/demux1to4_tdm.sv
// demux1to4_tdm: time-division 1-to-4 demultiplexer.
// Hunts for a FRAME marker, then steers each accepted serial sample into
// shadow slots 0..2. The slot-3 sample transfers the whole frame to A-D
// on one edge and raises a one-cycle FRAME_DONE.
// Optional feature macro: DEMUX_SYNC_CHECK_EN. When it is defined, a FRAME
// marker seen away from slot 0 while locked flags SYNC_ERR and restarts
// the frame at slot 0. When it is undefined, FRAME is ignored while locked.
module demux1to4_tdm #(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] demuxIN,
  input  logic             IN_VALID,
  input  logic             FRAME,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic             S0,
  output logic             S1,
  output logic             LOCKED,
  output logic             FRAME_DONE,
  output logic             SYNC_ERR
);

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t           r_state;
  logic [1:0]       r_slot;
  logic [WIDTH-1:0] r_sh0;
  logic [WIDTH-1:0] r_sh1;
  logic [WIDTH-1:0] r_sh2;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_c;
  logic [WIDTH-1:0] r_d;
  logic             r_frame_done;

  state_t           w_state_nxt;
  logic [1:0]       w_slot_nxt;
  logic [WIDTH-1:0] w_sh0_nxt;
  logic [WIDTH-1:0] w_sh1_nxt;
  logic [WIDTH-1:0] w_sh2_nxt;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic [WIDTH-1:0] w_c_nxt;
  logic [WIDTH-1:0] w_d_nxt;
  logic             w_frame_done_nxt;

`ifdef DEMUX_SYNC_CHECK_EN
  logic             r_sync_err;
  logic             w_sync_err_nxt;
`endif

  // Next-state logic: everything holds unless a sample is accepted; the
  // pulse outputs default low so they last a single cycle.
  always_comb begin
    w_state_nxt      = r_state;
    w_slot_nxt       = r_slot;
    w_sh0_nxt        = r_sh0;
    w_sh1_nxt        = r_sh1;
    w_sh2_nxt        = r_sh2;
    w_a_nxt          = r_a;
    w_b_nxt          = r_b;
    w_c_nxt          = r_c;
    w_d_nxt          = r_d;
    w_frame_done_nxt = 1'b0;
`ifdef DEMUX_SYNC_CHECK_EN
    w_sync_err_nxt   = 1'b0;
`endif
    if (IN_VALID) begin
      case (r_state)
        ST_HUNT: begin
          // Samples ahead of the first marker are dropped; the marker
          // sample itself is slot 0 of the first tracked frame.
          if (FRAME) begin
            w_sh0_nxt   = demuxIN;
            w_slot_nxt  = 2'd1;
            w_state_nxt = ST_LOCK;
          end
        end
        ST_LOCK: begin
`ifdef DEMUX_SYNC_CHECK_EN
          // Misplaced marker: abandon the partial frame and realign so this
          // sample becomes slot 0. A-D keep the last completed frame.
          if (FRAME && (r_slot != 2'd0)) begin
            w_sync_err_nxt = 1'b1;
            w_sh0_nxt      = demuxIN;
            w_sh1_nxt      = '0;
            w_sh2_nxt      = '0;
            w_slot_nxt     = 2'd1;
          end else
`endif
          begin
            case (r_slot)
              2'd0: w_sh0_nxt = demuxIN;
              2'd1: w_sh1_nxt = demuxIN;
              2'd2: w_sh2_nxt = demuxIN;
              default: begin
                // Slot 3 closes the frame: publish all four channels at once.
                w_a_nxt          = r_sh0;
                w_b_nxt          = r_sh1;
                w_c_nxt          = r_sh2;
                w_d_nxt          = demuxIN;
                w_frame_done_nxt = 1'b1;
              end
            endcase
            w_slot_nxt = r_slot + 2'd1;
          end
        end
        default: begin
          w_state_nxt = ST_HUNT;
          w_slot_nxt  = 2'd0;
        end
      endcase
    end
  end

  // State, slot, shadow and output registers; reset discards any partial frame.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= ST_HUNT;
      r_slot       <= 2'd0;
      r_sh0        <= '0;
      r_sh1        <= '0;
      r_sh2        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_c          <= '0;
      r_d          <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_slot       <= w_slot_nxt;
      r_sh0        <= w_sh0_nxt;
      r_sh1        <= w_sh1_nxt;
      r_sh2        <= w_sh2_nxt;
      r_a          <= w_a_nxt;
      r_b          <= w_b_nxt;
      r_c          <= w_c_nxt;
      r_d          <= w_d_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

`ifdef DEMUX_SYNC_CHECK_EN
  // Resync pulse register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sync_err <= 1'b0;
    end else begin
      r_sync_err <= w_sync_err_nxt;
    end
  end

  assign SYNC_ERR = r_sync_err;
`else
  assign SYNC_ERR = 1'b0;
`endif

  assign A          = r_a;
  assign B          = r_b;
  assign C          = r_c;
  assign D          = r_d;
  assign S0         = r_slot[0];
  assign S1         = r_slot[1];
  assign LOCKED     = (r_state == ST_LOCK);
  assign FRAME_DONE = r_frame_done;

endmodule

// File: tb/tb_demux1to4_tdm.sv
// Testbench for demux1to4_tdm (WIDTH=4). A queue-based frame model tracks
// which samples have been collected in the current frame; the slot is simply
// how many samples that frame holds so far.
module tb_demux1to4_tdm;

  logic       CLK;
  logic       RESET;
  logic [3:0] demuxIN;
  logic       IN_VALID;
  logic       FRAME;
  logic [3:0] A, B, C, D;
  logic       S0, S1, LOCKED, FRAME_DONE, SYNC_ERR;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic       m_locked;
  logic [3:0] m_q[$];
  logic [3:0] m_out[4];
  logic       m_done;
  logic       m_err;

  demux1to4_tdm #(.WIDTH(4)) dut (
    .CLK(CLK), .RESET(RESET), .demuxIN(demuxIN), .IN_VALID(IN_VALID),
    .FRAME(FRAME), .A(A), .B(B), .C(C), .D(D), .S0(S0), .S1(S1),
    .LOCKED(LOCKED), .FRAME_DONE(FRAME_DONE), .SYNC_ERR(SYNC_ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [20:0] got_vec();
    return {A, B, C, D, S1, S0, LOCKED, FRAME_DONE, SYNC_ERR};
  endfunction

  function automatic logic [20:0] exp_vec();
    logic [1:0] s;
    s = 2'(m_q.size());
    return {m_out[0], m_out[1], m_out[2], m_out[3], s[1], s[0], m_locked, m_done, m_err};
  endfunction

  // Apply one cycle of inputs, clock it, advance the model, settle for sampling.
  task automatic drive(input logic rst, input logic v, input logic f, input logic [3:0] d);
    RESET = rst; IN_VALID = v; FRAME = f; demuxIN = d;
    @(posedge CLK);
    m_done = 1'b0;
    m_err  = 1'b0;
    if (rst) begin
      m_locked = 1'b0;
      m_q.delete();
      for (int i = 0; i < 4; i++) m_out[i] = 4'd0;
    end else if (v) begin
      if (!m_locked) begin
        if (f) begin
          m_q.delete();
          m_q.push_back(d);
          m_locked = 1'b1;
        end
      end else begin
`ifdef DEMUX_SYNC_CHECK_EN
        if (f && m_q.size() != 0) begin
          m_err = 1'b1;
          m_q.delete();
          m_q.push_back(d);
        end else
`endif
        begin
          m_q.push_back(d);
          if (m_q.size() == 4) begin
            for (int i = 0; i < 4; i++) m_out[i] = m_q[i];
            m_done = 1'b1;
            m_q.delete();
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b1, 4'hF);
      n_assert++;
      if (got_vec() !== 21'd0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %h expected %h", i, got_vec(), 21'd0);
      end
      n_assert++;
      if (got_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_model[%0d]: got %h expected %h", i, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_hunt_lock();
    logic [3:0] pre[3] = '{4'd1, 4'd0, 4'd1};
    logic [3:0] frm[4] = '{4'd1, 4'd0, 4'd1, 4'd1};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, pre[i]);
      n_assert++;
      if ({LOCKED, S1, S0} !== 3'b000) begin
        n_fail++;
        $display("FAIL hunt_drop[%0d]: got %b expected 000", i, {LOCKED, S1, S0});
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, (i == 0), frm[i]);
      n_assert++;
      if (got_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL hunt_lock[%0d]: got %h expected %h", i, got_vec(), exp_vec());
      end
      if (i == 0) begin
        n_assert++;
        if ({LOCKED, S1, S0} !== 3'b101) begin
          n_fail++;
          $display("FAIL lock_entry: got %b expected 101", {LOCKED, S1, S0});
        end
      end
    end
    n_assert++;
    if ({A, B, C, D, FRAME_DONE} !== {16'h1011, 1'b1}) begin
      n_fail++;
      $display("FAIL hunt_frame: got %h/%b expected 1011/1", {A, B, C, D}, FRAME_DONE);
    end
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    n_assert++;
    if (FRAME_DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: got %b expected 0", FRAME_DONE);
    end
  endtask

  task automatic test_gaps();
    logic [3:0] frm[4] = '{4'd0, 4'd1, 4'd1, 4'd0};
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1, (k == 0), frm[k]);
      n_assert++;
      if (got_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL gaps_accept[%0d]: got %h expected %h", k, got_vec(), exp_vec());
      end
      if (k < 3) begin
        for (int g = 0; g < 3; g++) begin
          drive(1'b0, 1'b0, 1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)));
          n_assert++;
          if ({S1, S0, FRAME_DONE, A, B, C, D} !== {2'(k + 1), 1'b0, 16'h1011}) begin
            n_fail++;
            $display("FAIL gaps_hold[%0d.%0d]: got %h expected %h", k, g,
                     {S1, S0, FRAME_DONE, A, B, C, D}, {2'(k + 1), 1'b0, 16'h1011});
          end
        end
      end
    end
    n_assert++;
    if ({A, B, C, D, FRAME_DONE} !== {16'h0110, 1'b1}) begin
      n_fail++;
      $display("FAIL gaps_frame: got %h/%b expected 0110/1", {A, B, C, D}, FRAME_DONE);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 1'b1, (i == 1 || i == 5), 4'(i));
      n_assert++;
      if (got_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got %h expected %h", i, got_vec(), exp_vec());
      end
      n_assert++;
      if (FRAME_DONE !== (i == 4 || i == 8)) begin
        n_fail++;
        $display("FAIL b2b_done[%0d]: got %b expected %b", i, FRAME_DONE, (i == 4 || i == 8));
      end
    end
    n_assert++;
    if ({A, B, C, D} !== 16'h5678) begin
      n_fail++;
      $display("FAIL b2b_frame: got %h expected 5678", {A, B, C, D});
    end
  endtask

  task automatic test_resync();
    logic [3:0] dat[6] = '{4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14};
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, (i == 0 || i == 2), dat[i]);
      n_assert++;
      if (got_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL resync[%0d]: got %h expected %h", i, got_vec(), exp_vec());
      end
      if (i == 2) begin
        n_assert++;
`ifdef DEMUX_SYNC_CHECK_EN
        if ({SYNC_ERR, FRAME_DONE, S1, S0, A, B, C, D} !== {4'b1001, 16'h5678}) begin
          n_fail++;
          $display("FAIL resync_mark: got %h expected %h",
                   {SYNC_ERR, FRAME_DONE, S1, S0, A, B, C, D}, {4'b1001, 16'h5678});
        end
`else
        if ({SYNC_ERR, FRAME_DONE, S1, S0} !== 4'b0011) begin
          n_fail++;
          $display("FAIL resync_mark: got %b expected 0011", {SYNC_ERR, FRAME_DONE, S1, S0});
        end
`endif
      end
    end
    n_assert++;
`ifdef DEMUX_SYNC_CHECK_EN
    if ({A, B, C, D} !== 16'hBCDE) begin
      n_fail++;
      $display("FAIL resync_frame: got %h expected BCDE", {A, B, C, D});
    end
`else
    if ({A, B, C, D} !== 16'h9ABC) begin
      n_fail++;
      $display("FAIL resync_frame: got %h expected 9ABC", {A, B, C, D});
    end
`endif
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    drive(1'b0, 1'b1, 1'b1, 4'd3);
    drive(1'b0, 1'b1, 1'b0, 4'd7);
    drive(1'b1, 1'b1, 1'b0, 4'd5);
    n_assert++;
    if ({LOCKED, S1, S0, A, B, C, D} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got %h expected 0", {LOCKED, S1, S0, A, B, C, D});
    end
    // Reset coinciding with a slot-3 accept must win.
    drive(1'b0, 1'b1, 1'b1, 4'd1);
    drive(1'b0, 1'b1, 1'b0, 4'd2);
    drive(1'b0, 1'b1, 1'b0, 4'd3);
    drive(1'b1, 1'b1, 1'b0, 4'd4);
    n_assert++;
    if ({FRAME_DONE, LOCKED, A, B, C, D} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_slot3: got %h expected 0", {FRAME_DONE, LOCKED, A, B, C, D});
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, (i == 0), 4'(6 + i));
      n_assert++;
      if (got_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_fresh[%0d]: got %h expected %h", i, got_vec(), exp_vec());
      end
    end
    n_assert++;
    if ({A, B, C, D, FRAME_DONE} !== {16'h6789, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_fresh_frame: got %h/%b expected 6789/1", {A, B, C, D}, FRAME_DONE);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(99, 0) < 2), ($urandom_range(99, 0) < 70),
            ($urandom_range(99, 0) < 25), 4'($urandom_range(15, 0)));
      n_assert++;
      if (got_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h expected %h", i, got_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    RESET = 1'b1; IN_VALID = 1'b1; FRAME = 1'b1; demuxIN = 4'd0;
    m_locked = 1'b0; m_done = 1'b0; m_err = 1'b0;
    for (int i = 0; i < 4; i++) m_out[i] = 4'd0;
    test_reset();
    test_hunt_lock();
    test_gaps();
    test_back_to_back();
    test_resync();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
